// File: rtl/wm_plant_model.sv
// wm_plant_model
//   Synthesizable plant model for the washing-machine controller. It sits at
//   the responder end of the sensor/actuator interface. It takes actuator
//   commands and user pulses, and drives the sensor levels and pulses that the
//   controller consumes.
//
// Ports
//   clk, reset          clock; asynchronous active-high reset
//   door_close_req      user closes door (pulse)
//   door_open_req       user opens door (pulse)
//   start_req           user presses start (pulse)
//   detergent_req       user loads detergent (pulse)
//   fault_clr           clears sticky fault bits
//   door_lock, motor_on, fill_valve_on, drain_valve_on   controller actuators
//   soap_wash, done     controller phase / completion flags
//   door_close          door sensor (level)
//   start               start sensor, held until the controller locks the door
//   filled, drained     drum full / drum empty (decoded from water_level)
//   detergent_added     dispenser complete
//   cycle_timeout       wash timer expiry (1-cycle pulse)
//   spin_timeout        spin timer expiry (1-cycle pulse)
//   water_level         current level, 0..FILL_CYCLES
//   fault               sticky: [0] valve conflict, [1] open while locked,
//                       [2] dry agitation
//
// Build option
//   WM_PLANT_AUTO_LOAD_EN : when defined, the dispenser triggers on the rising
//   edge of soap_wash while the drum is full and the motor is off, and
//   detergent_req is ignored. When undefined, detergent_req triggers the
//   dispenser. A request made outside the soap phase is held pending until the
//   soap phase starts.
module wm_plant_model #(
    parameter int FILL_CYCLES = 16,
    parameter int WASH_CYCLES = 32,
    parameter int SPIN_CYCLES = 24,
    parameter int DET_CYCLES  = 4,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             door_close_req,
    input  logic             door_open_req,
    input  logic             start_req,
    input  logic             detergent_req,
    input  logic             fault_clr,
    input  logic             door_lock,
    input  logic             motor_on,
    input  logic             fill_valve_on,
    input  logic             drain_valve_on,
    input  logic             soap_wash,
    input  logic             done,
    output logic             door_close,
    output logic             start,
    output logic             filled,
    output logic             detergent_added,
    output logic             cycle_timeout,
    output logic             drained,
    output logic             spin_timeout,
    output logic [CNT_W-1:0] water_level,
    output logic [2:0]       fault
);

    localparam logic [CNT_W-1:0] LVL_FULL  = CNT_W'(FILL_CYCLES);
    localparam logic [CNT_W-1:0] WASH_LAST = CNT_W'(WASH_CYCLES - 1);
    localparam logic [CNT_W-1:0] SPIN_LAST = CNT_W'(SPIN_CYCLES - 1);
    localparam logic [CNT_W-1:0] DET_LAST  = CNT_W'(DET_CYCLES - 1);

    localparam logic [1:0] D_IDLE = 2'd0;
    localparam logic [1:0] D_WAIT = 2'd1;
    localparam logic [1:0] D_DONE = 2'd2;

    logic [CNT_W-1:0] wash_cnt;
    logic [CNT_W-1:0] spin_cnt;
    logic [CNT_W-1:0] det_cnt;
    logic [1:0]       d_state;
    logic             det_trig;
    logic             spin_run;
    logic [2:0]       fault_set;

    assign filled          = (water_level == LVL_FULL);
    assign drained         = (water_level == '0);
    assign detergent_added = (d_state == D_DONE);
    assign spin_run        = drain_valve_on & drained;

    // Door and start sensors
    // Open takes priority over close. While the door is locked, an open
    // request is dropped and the event is recorded in fault[1].
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            door_close <= 1'b0;
            start      <= 1'b0;
        end else begin
            if (door_open_req) begin
                if (!door_lock) door_close <= 1'b0;
            end else if (door_close_req) begin
                door_close <= 1'b1;
            end
            // The start stretch ends once the controller acknowledges it by
            // locking the door. A new press has priority over that clear.
            if (start_req)
                start <= 1'b1;
            else if (start && door_lock)
                start <= 1'b0;
        end
    end

    // Drum level
    // Only one valve may be open for the level to change. With both open
    // the level holds.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            water_level <= '0;
        end else begin
            case ({fill_valve_on, drain_valve_on})
                2'b10: if (water_level != LVL_FULL) water_level <= water_level + 1'b1;
                2'b01: if (water_level != '0)       water_level <= water_level - 1'b1;
                default: ;
            endcase
        end
    end

    // Wash and spin timers
    // Each timer reloads 0 when it expires, so the pulses repeat every N
    // cycles while the enabling condition stays true.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wash_cnt      <= '0;
            cycle_timeout <= 1'b0;
            spin_cnt      <= '0;
            spin_timeout  <= 1'b0;
        end else begin
            cycle_timeout <= 1'b0;
            if (!motor_on) begin
                wash_cnt <= '0;
            end else if (wash_cnt == WASH_LAST) begin
                wash_cnt      <= '0;
                cycle_timeout <= 1'b1;
            end else begin
                wash_cnt <= wash_cnt + 1'b1;
            end

            spin_timeout <= 1'b0;
            if (!spin_run) begin
                spin_cnt <= '0;
            end else if (spin_cnt == SPIN_LAST) begin
                spin_cnt     <= '0;
                spin_timeout <= 1'b1;
            end else begin
                spin_cnt <= spin_cnt + 1'b1;
            end
        end
    end

    // Dispenser trigger
`ifdef WM_PLANT_AUTO_LOAD_EN
    logic soap_wash_q;
    logic unused_detergent_req;

    assign unused_detergent_req = detergent_req;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) soap_wash_q <= 1'b0;
        else       soap_wash_q <= soap_wash;
    end

    assign det_trig = soap_wash & ~soap_wash_q & filled & ~motor_on;
`else
    logic det_pending;

    // A request made outside the soap phase is held in det_pending. The
    // first soap_wash cycle consumes it. Opening the door discards it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)              det_pending <= 1'b0;
        else if (!door_close)   det_pending <= 1'b0;
        else if (soap_wash)     det_pending <= 1'b0;
        else if (detergent_req) det_pending <= 1'b1;
    end

    assign det_trig = soap_wash & (detergent_req | det_pending);
`endif

    // Dispenser FSM
    // The trigger cycle counts as the first cycle of delay. det_cnt starts
    // at 1 on entry to D_WAIT, so detergent_added rises DET_CYCLES cycles
    // after the trigger cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            d_state <= D_IDLE;
            det_cnt <= '0;
        end else if (!door_close) begin
            d_state <= D_IDLE;
            det_cnt <= '0;
        end else begin
            case (d_state)
                D_IDLE: begin
                    if (det_trig) begin
                        d_state <= (DET_CYCLES <= 1) ? D_DONE : D_WAIT;
                        det_cnt <= CNT_W'(1);
                    end
                end
                D_WAIT: begin
                    if (det_cnt == DET_LAST) begin
                        d_state <= D_DONE;
                        det_cnt <= '0;
                    end else begin
                        det_cnt <= det_cnt + 1'b1;
                    end
                end
                D_DONE: begin
                    if (!soap_wash || done) d_state <= D_IDLE;
                end
                default: d_state <= D_IDLE;
            endcase
        end
    end

    // Sticky faults
    // When a fault condition and fault_clr occur in the same cycle, the
    // fault condition wins.
    assign fault_set = {motor_on & drained,
                        door_open_req & door_lock,
                        fill_valve_on & drain_valve_on};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) fault <= 3'b000;
        else       fault <= (fault_clr ? 3'b000 : fault) | fault_set;
    end

endmodule

// File: tb/tb_wm_plant_model.sv
module tb_wm_plant_model;

    localparam int FILL = 16;
    localparam int WASH = 32;
    localparam int SPIN = 24;
    localparam int DET  = 4;
    localparam int CW   = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic door_close_req = 0, door_open_req = 0, start_req = 0, detergent_req = 0;
    logic fault_clr = 0, door_lock = 0, motor_on = 0, fill_valve_on = 0, drain_valve_on = 0;
    logic soap_wash = 0, done = 0;
    logic door_close, start, filled, detergent_added, cycle_timeout, drained, spin_timeout;
    logic [CW-1:0] water_level;
    logic [2:0] fault;

    int checks = 0;
    int failures = 0;

    // Reference model: plain integers describing the plant's observable state.
    int m_door, m_st, m_lvl, m_wrun, m_srun, m_ct, m_spt, m_dleft, m_pend, m_soap_prev;
    logic [2:0] m_f;

    always #5 clk = ~clk;

    wm_plant_model #(
        .FILL_CYCLES(FILL), .WASH_CYCLES(WASH), .SPIN_CYCLES(SPIN),
        .DET_CYCLES(DET), .CNT_W(CW)
    ) dut (
        .clk(clk), .reset(reset),
        .door_close_req(door_close_req), .door_open_req(door_open_req),
        .start_req(start_req), .detergent_req(detergent_req), .fault_clr(fault_clr),
        .door_lock(door_lock), .motor_on(motor_on), .fill_valve_on(fill_valve_on),
        .drain_valve_on(drain_valve_on), .soap_wash(soap_wash), .done(done),
        .door_close(door_close), .start(start), .filled(filled),
        .detergent_added(detergent_added), .cycle_timeout(cycle_timeout),
        .drained(drained), .spin_timeout(spin_timeout),
        .water_level(water_level), .fault(fault)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_door = 0; m_st = 0; m_lvl = 0; m_wrun = 0; m_srun = 0; m_ct = 0; m_spt = 0;
        m_dleft = -1; m_pend = 0; m_soap_prev = 0; m_f = 3'b000;
    endtask

    task automatic compare_all();
        chk("door_close", {31'd0, door_close}, m_door);
        chk("start", {31'd0, start}, m_st);
        chk("water_level", {24'd0, water_level}, m_lvl);
        chk("filled", {31'd0, filled}, (m_lvl == FILL) ? 1 : 0);
        chk("drained", {31'd0, drained}, (m_lvl == 0) ? 1 : 0);
        chk("cycle_timeout", {31'd0, cycle_timeout}, m_ct);
        chk("spin_timeout", {31'd0, spin_timeout}, m_spt);
        chk("detergent_added", {31'd0, detergent_added}, (m_dleft == 0) ? 1 : 0);
        chk("fault", {29'd0, fault}, {29'd0, m_f});
    endtask

    // Advance one clock. The model's next state is computed from the inputs
    // that are present at the edge.
    task automatic step();
        int n_door, n_st, n_lvl, n_wrun, n_srun, n_ct, n_spt, n_dleft, n_pend;
        logic [2:0] n_f;
        bit trig;
        n_door = m_door;
        if (door_open_req) begin
            if (!door_lock) n_door = 0;
        end else if (door_close_req) n_door = 1;
        n_st = start_req ? 1 : ((m_st == 1 && door_lock) ? 0 : m_st);
        n_lvl = m_lvl;
        if (fill_valve_on && !drain_valve_on) n_lvl = (m_lvl >= FILL) ? FILL : m_lvl + 1;
        else if (drain_valve_on && !fill_valve_on) n_lvl = (m_lvl == 0) ? 0 : m_lvl - 1;
        if (motor_on) begin
            n_wrun = m_wrun + 1; n_ct = (n_wrun % WASH == 0) ? 1 : 0;
        end else begin
            n_wrun = 0; n_ct = 0;
        end
        if (drain_valve_on && m_lvl == 0) begin
            n_srun = m_srun + 1; n_spt = (n_srun % SPIN == 0) ? 1 : 0;
        end else begin
            n_srun = 0; n_spt = 0;
        end
        n_f = fault_clr ? 3'b000 : m_f;
        if (fill_valve_on && drain_valve_on) n_f[0] = 1'b1;
        if (door_open_req && door_lock) n_f[1] = 1'b1;
        if (motor_on && m_lvl == 0) n_f[2] = 1'b1;
`ifdef WM_PLANT_AUTO_LOAD_EN
        trig = soap_wash && m_soap_prev == 0 && m_lvl == FILL && !motor_on;
        n_pend = 0;
`else
        trig = soap_wash && (detergent_req || m_pend == 1);
        n_pend = soap_wash ? 0 : (detergent_req ? 1 : m_pend);
`endif
        // m_dleft: -1 idle, >0 cycles until complete, 0 complete
        n_dleft = m_dleft;
        if (m_dleft < 0) begin
            if (trig) n_dleft = DET - 1;
        end else if (m_dleft > 0) n_dleft = m_dleft - 1;
        else if (!soap_wash || done) n_dleft = -1;
        if (m_door == 0) begin
            n_dleft = -1; n_pend = 0;
        end
        m_soap_prev = soap_wash ? 1 : 0;
        @(posedge clk);
        m_door = n_door; m_st = n_st; m_lvl = n_lvl; m_wrun = n_wrun; m_srun = n_srun;
        m_ct = n_ct; m_spt = n_spt; m_dleft = n_dleft; m_pend = n_pend; m_f = n_f;
        #1;
        compare_all();
    endtask

    task automatic clear_inputs();
        door_close_req = 0; door_open_req = 0; start_req = 0; detergent_req = 0;
        fault_clr = 0; door_lock = 0; motor_on = 0; fill_valve_on = 0; drain_valve_on = 0;
        soap_wash = 0; done = 0;
    endtask

    initial begin
        int pulses, at, lvl_before;
        clear_inputs();
        model_reset();
        // Reset state
        repeat (2) @(negedge clk);
        compare_all();
        reset = 1'b0;

        // Door close, then start, then the controller locks the door
        door_close_req = 1;
        step();
        chk("door_close@1", {31'd0, door_close}, 1);
        door_close_req = 0; start_req = 1;
        step();
        chk("start@2", {31'd0, start}, 1);
        start_req = 0;
        step();
        chk("start@3", {31'd0, start}, 1);
        door_lock = 1;
        step();
        chk("start@4", {31'd0, start}, 0);

        // Fill to full, then keep the fill valve open at full
        fill_valve_on = 1;
        repeat (FILL) step();
        chk("level_full", {24'd0, water_level}, FILL);
        chk("filled_full", {31'd0, filled}, 1);
        repeat (3) step();
        chk("level_sat", {24'd0, water_level}, FILL);
        chk("no_fault_fill", {29'd0, fault}, 0);
        fill_valve_on = 0;

        // Continuous agitation: the timeout pulses at cycle 32 and cycle 64
        motor_on = 1; pulses = 0; at = 0;
        for (int i = 1; i <= 2 * WASH; i++) begin
            step();
            if (cycle_timeout) begin
                pulses++;
                if (at == 0) at = i;
            end
        end
        chk("wash_pulses", pulses, 2);
        chk("wash_first_at", at, WASH);
        chk("no_dry_fault", {31'd0, fault[2]}, 0);
        motor_on = 0;

        // Drain to empty, then keep the drain valve open for the spin
        drain_valve_on = 1;
        repeat (FILL) step();
        chk("drained", {31'd0, drained}, 1);
        pulses = 0; at = 0;
        for (int i = 1; i <= SPIN; i++) begin
            step();
            if (spin_timeout) begin
                pulses++;
                at = i;
            end
        end
        chk("spin_pulses", pulses, 1);
        chk("spin_at", at, SPIN);
        drain_valve_on = 0;

        // Valve conflict at level 5; open while locked; fault clear
        fill_valve_on = 1;
        repeat (5) step();
        drain_valve_on = 1;
        repeat (3) step();
        chk("conflict_level", {24'd0, water_level}, 5);
        chk("fault0", {31'd0, fault[0]}, 1);
        fill_valve_on = 0; drain_valve_on = 0;
        door_open_req = 1;
        step();
        door_open_req = 0;
        chk("door_locked", {31'd0, door_close}, 1);
        chk("fault1", {31'd0, fault[1]}, 1);
        fault_clr = 1;
        step();
        fault_clr = 0;
        chk("fault_clr", {29'd0, fault}, 0);

        // Dispenser: fill to full, request outside the soap phase, then enter the soap phase
        fill_valve_on = 1;
        repeat (FILL - 5) step();
        fill_valve_on = 0;
        detergent_req = 1;
        step();
        detergent_req = 0; soap_wash = 1; at = 0;
        for (int i = 1; i <= 10 && at == 0; i++) begin
            step();
            if (detergent_added) at = i;
        end
        chk("det_latency", at, DET);
        soap_wash = 0;
        step();
        chk("det_drop", {31'd0, detergent_added}, 0);

        // Reset during a fill: the level is dropped at once, without a clock edge
        door_lock = 0;
        fill_valve_on = 1; drain_valve_on = 1;
        step();
        drain_valve_on = 0;
        lvl_before = water_level;
        step();
        chk("mid_fill_level", {24'd0, water_level}, lvl_before < FILL ? lvl_before + 1 : FILL);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("async_level", {24'd0, water_level}, 0);
        chk("async_drained", {31'd0, drained}, 1);
        chk("async_fault", {29'd0, fault}, 0);
        clear_inputs();
        model_reset();
        @(negedge clk);
        compare_all();
        reset = 1'b0;

        // Random closed-loop-ish traffic checked against the model
        for (int i = 0; i < 700; i++) begin
            door_close_req = ($urandom_range(0, 5) == 0);
            door_open_req  = ($urandom_range(0, 11) == 0);
            start_req      = ($urandom_range(0, 9) == 0);
            detergent_req  = ($urandom_range(0, 7) == 0);
            fault_clr      = ($urandom_range(0, 15) == 0);
            done           = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 9) == 0) door_lock      = ~door_lock;
            if ($urandom_range(0, 7) == 0) motor_on       = ~motor_on;
            if ($urandom_range(0, 5) == 0) fill_valve_on  = ~fill_valve_on;
            if ($urandom_range(0, 6) == 0) drain_valve_on = ~drain_valve_on;
            if ($urandom_range(0, 9) == 0) soap_wash      = ~soap_wash;
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wm_plant_model.md
Name: wm_plant_model

Overview:
Behavioural-but-synthesizable plant model for the washing-machine controller: the responder end of the controller's sensor/actuator interface. Consumes actuator commands (door_lock, motor_on, fill/drain valves, phase flags) and produces the sensor signals the controller consumes (door_close, start, filled, detergent_added, cycle_timeout, drained, spin_timeout). Used on-chip for closed-loop self-test via LA/IO, and as the bench environment for the controller.

Parameters:
FILL_CYCLES, 16, cycles of exclusive fill to go from empty to full; also the full-level value
WASH_CYCLES, 32, cycles of continuous agitation before cycle_timeout
SPIN_CYCLES, 24, cycles of drain-with-empty-drum before spin_timeout
DET_CYCLES, 4, dispenser delay from request to detergent_added
CNT_W, 8, width of all internal counters; every *_CYCLES value must be < 2^CNT_W

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
door_close_req  in  1  user closes door (1-cycle pulse)
door_open_req  in  1  user opens door (1-cycle pulse)
start_req  in  1  user presses start (1-cycle pulse)
detergent_req  in  1  user loads detergent (1-cycle pulse; ignored when WM_PLANT_AUTO_LOAD_EN is defined)
fault_clr  in  1  clears sticky fault bits
door_lock  in  1  controller actuator
motor_on  in  1  controller actuator
fill_valve_on  in  1  controller actuator
drain_valve_on  in  1  controller actuator
soap_wash  in  1  controller phase flag
done  in  1  controller completion flag
door_close  out  1  door sensor (level)
start  out  1  start sensor (level, stretched)
filled  out  1  drum full
detergent_added  out  1  dispenser complete
cycle_timeout  out  1  wash timer expiry (1-cycle pulse)
drained  out  1  drum empty
spin_timeout  out  1  spin timer expiry (1-cycle pulse)
water_level  out  CNT_W  current level, 0..FILL_CYCLES
fault  out  3  sticky faults: [0] valve conflict, [1] open while locked, [2] dry agitation

Behaviour:
- Reset values: door_close=0, start=0, detergent_added=0, cycle_timeout=0, spin_timeout=0, water_level=0, fault=0; hence drained=1, filled=0. All counters 0.
- Door: door_close_req sets door_close next cycle. door_open_req clears it only when door_lock=0; if door_lock=1, request ignored and fault[1] set. Both requests in the same cycle: open wins (subject to lock rule).
- Start: start_req sets start next cycle. start held until door_lock is sampled 1, then cleared the following cycle. start_req with door_close=0: start still set (controller gates it).
- Level: fill_valve_on & !drain_valve_on -> +1/cycle, saturating at FILL_CYCLES. drain_valve_on & !fill_valve_on -> -1/cycle, saturating at 0. Both on -> hold, fault[0] set. filled = (water_level==FILL_CYCLES), drained = (water_level==0); combinational decode of the registered level, so visible one cycle after the edge that reaches the bound.
- Wash timer: counts while motor_on=1; clears when motor_on=0. When count==WASH_CYCLES-1, cycle_timeout pulses 1 cycle and the counter reloads 0 (a further expiry requires another WASH_CYCLES). motor_on with water_level==0 sets fault[2]; timer still runs.
- Spin timer: counts while drain_valve_on=1 and water_level==0; clears otherwise. When count==SPIN_CYCLES-1, spin_timeout pulses 1 cycle and the counter reloads 0.
- Dispenser FSM states: D_IDLE, D_WAIT, D_DONE.
  - D_IDLE -> D_WAIT on trigger; the trigger is defined under Optional Feature.
  - D_WAIT counts DET_CYCLES, then -> D_DONE.
  - D_DONE drives detergent_added=1; -> D_IDLE when soap_wash=0 or done=1.
  - Any state -> D_IDLE when door_close=0.
- Faults: sticky, cleared by fault_clr. A set condition in the same cycle as fault_clr wins (bit stays 1).
- Reset mid-operation: all state returns to reset values asynchronously. A level in progress is discarded; the drum model reads empty.

Optional Feature:
Macro WM_PLANT_AUTO_LOAD_EN.
- Defined: the D_IDLE->D_WAIT trigger is the rising edge of soap_wash while filled=1 and motor_on=0. detergent_req is ignored.
- Undefined: the trigger is detergent_req while soap_wash=1. A detergent_req while soap_wash=0 is latched in a single pending bit and consumed on the first cycle soap_wash=1; the pending bit is cleared when door_close=0.

Test Plan:
- Reset, then door_close_req, then start_req; hold door_lock=1 from cycle 3 -> door_close=1 at cycle 1; start=1 at cycles 2-3, start=0 at cycle 4.
- fill_valve_on=1 for 16 cycles (defaults) -> water_level climbs 0..16; filled=1 from the cycle after the 16th edge; further fill holds at 16, no fault.
- motor_on=1 continuously at level 16 -> cycle_timeout pulses once at cycle 32, again at cycle 64; fault[2]=0.
- Drain to 0, then keep drain_valve_on=1 -> drained=1; spin_timeout pulses 24 cycles after level reaches 0.
- fill_valve_on and drain_valve_on both 1 at level 5 -> level stays 5, fault[0]=1. door_open_req with door_lock=1 -> door_close stays 1, fault[1]=1. fault_clr -> fault=0.
- Without the macro: detergent_req with soap_wash=0, then soap_wash=1 -> detergent_added=1 DET_CYCLES (4) cycles later. With the macro: soap_wash rises at filled=1, motor_on=0 -> same 4-cycle response. soap_wash=0 -> detergent_added=0 next cycle.
